// File: rtl/pc_redirect_unit.sv
// pc_redirect_unit
//   Owns the fetch PC, sequences fetch requests to instruction memory and
//   applies jump/branch redirects from EX. When a fetch is in flight, the
//   redirect target is latched until the fetch completes. Wrong-path
//   instructions are killed by driving the IF/ID flush.
//
// Optional feature (macro PC_MISALIGN_TRAP_EN):
//   When defined, a target with [1:0] != 0 sends fetch to TRAP_VECTOR. The
//   offending target is reported on bad_addr and misalign_trap pulses high.
//   When undefined, target bits [1:0] are forced to 00.
//
// Ports:
//   clk, rst_n          clock (rising edge), async active-low reset
//   stall               hazard unit holds the PC
//   jb_valid, jb_target taken jump/branch and its target from EX
//   imem_ready          instruction memory accepts/completes current fetch
//   pc_out              current fetch address
//   fetch_valid         pc_out is a valid fetch request
//   flush               kill IF/ID contents
//   redirect_pending    redirect latched, waiting for imem_ready
//   misalign_trap       (macro only) one-cycle trap pulse
//   bad_addr            (macro only) last misaligned target
module pc_redirect_unit #(
    parameter logic [31:0] RESET_PC     = 32'h0000_0000,
    parameter int unsigned FLUSH_CYCLES = 2
`ifdef PC_MISALIGN_TRAP_EN
    ,
    parameter logic [31:0] TRAP_VECTOR  = 32'h0000_0100
`endif
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        stall,
    input  logic        jb_valid,
    input  logic [31:0] jb_target,
    input  logic        imem_ready,
    output logic [31:0] pc_out,
    output logic        fetch_valid,
    output logic        flush,
    output logic        redirect_pending
`ifdef PC_MISALIGN_TRAP_EN
    ,
    output logic        misalign_trap,
    output logic [31:0] bad_addr
`endif
);

    localparam int unsigned CNT_W = 3;
    localparam logic [CNT_W-1:0] FLUSH_LOAD = CNT_W'(FLUSH_CYCLES);

    typedef enum logic [1:0] {
        S_BOOT = 2'd0,
        S_RUN  = 2'd1,
        S_WAIT = 2'd2
    } state_e;

    state_e             state_q, state_d;
    logic [31:0]        pc_q, pc_d;
    logic [31:0]        tgt_q, tgt_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               fetch_valid_q;
    logic               pending_q;
    logic               flush_q;
    logic               accept;
    logic [31:0]        acc_tgt;
`ifdef PC_MISALIGN_TRAP_EN
    logic               trap_q, trap_d;
    logic [31:0]        bad_q, bad_d;
`endif

    // Next-state, PC and flush-counter logic.
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        tgt_d   = tgt_q;
        cnt_d   = (cnt_q != '0) ? cnt_q - CNT_W'(1) : cnt_q;
        accept  = 1'b0;
        acc_tgt = jb_target;
`ifdef PC_MISALIGN_TRAP_EN
        trap_d  = 1'b0;
        bad_d   = bad_q;
`endif

        case (state_q)
            S_BOOT: begin
                state_d = S_RUN;
            end
            S_RUN: begin
                // Redirect outranks stall; it only waits on the memory handshake.
                if (jb_valid) begin
                    if (imem_ready) begin
                        accept  = 1'b1;
                        acc_tgt = jb_target;
                    end else begin
                        tgt_d   = jb_target;
                        state_d = S_WAIT;
                    end
                end else if (!stall && imem_ready) begin
                    pc_d = pc_q + 32'd4;
                end
            end
            S_WAIT: begin
                // A fresh target in the completing cycle beats the latched one.
                if (imem_ready) begin
                    accept  = 1'b1;
                    acc_tgt = jb_valid ? jb_target : tgt_q;
                    state_d = S_RUN;
                end else if (jb_valid) begin
                    tgt_d = jb_target;
                end
            end
            default: begin
                state_d = S_BOOT;
            end
        endcase

        // Apply an accepted redirect.
        if (accept) begin
            cnt_d = FLUSH_LOAD;
`ifdef PC_MISALIGN_TRAP_EN
            if (acc_tgt[1:0] != 2'b00) begin
                pc_d   = TRAP_VECTOR;
                trap_d = 1'b1;
                bad_d  = acc_tgt;
            end else begin
                pc_d = acc_tgt;
            end
`else
            pc_d = acc_tgt & ~32'd3;
`endif
        end
    end

    // State and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= S_BOOT;
            pc_q          <= RESET_PC;
            tgt_q         <= '0;
            cnt_q         <= '0;
            fetch_valid_q <= 1'b0;
            pending_q     <= 1'b0;
            flush_q       <= 1'b0;
        end else begin
            state_q       <= state_d;
            pc_q          <= pc_d;
            tgt_q         <= tgt_d;
            cnt_q         <= cnt_d;
            fetch_valid_q <= (state_d != S_BOOT);
            pending_q     <= (state_d == S_WAIT);
            flush_q       <= (cnt_d != '0);
        end
    end

`ifdef PC_MISALIGN_TRAP_EN
    // Trap pulse and faulting-address registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            trap_q <= 1'b0;
            bad_q  <= '0;
        end else begin
            trap_q <= trap_d;
            bad_q  <= bad_d;
        end
    end

    assign misalign_trap = trap_q;
    assign bad_addr      = bad_q;
`endif

    assign pc_out           = pc_q;
    assign fetch_valid      = fetch_valid_q;
    assign flush            = flush_q;
    assign redirect_pending = pending_q;

endmodule

// File: tb/tb_pc_redirect_unit.sv
// Testbench for pc_redirect_unit: table of {inputs, expected outputs after
// the next clock edge}, pushed to a scoreboard queue when driven and popped
// when the outputs are sampled. Reset cases are hand-written.
module tb_pc_redirect_unit;

    logic        clk;
    logic        rst_n;
    logic        stall;
    logic        jb_valid;
    logic [31:0] jb_target;
    logic        imem_ready;
    logic [31:0] pc_out;
    logic        fetch_valid;
    logic        flush;
    logic        redirect_pending;
`ifdef PC_MISALIGN_TRAP_EN
    logic        misalign_trap;
    logic [31:0] bad_addr;
`endif

    int errors = 0;
    int checks = 0;

    pc_redirect_unit dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .stall            (stall),
        .jb_valid         (jb_valid),
        .jb_target        (jb_target),
        .imem_ready       (imem_ready),
        .pc_out           (pc_out),
        .fetch_valid      (fetch_valid),
        .flush            (flush),
        .redirect_pending (redirect_pending)
`ifdef PC_MISALIGN_TRAP_EN
        ,
        .misalign_trap    (misalign_trap),
        .bad_addr         (bad_addr)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        stall;
        logic        jb;
        logic        rdy;
        logic [31:0] tgt;
        logic [31:0] e_pc;
        logic        e_fv;
        logic        e_fl;
        logic        e_pd;
        logic        e_trap;
        logic [31:0] e_bad;
    } vec_t;

    vec_t vecs[$];
    vec_t exp_q[$];

    function automatic vec_t mk(input logic s, input logic j, input logic r,
                                input logic [31:0] t, input logic [31:0] pc,
                                input logic fv, input logic fl, input logic pd,
                                input logic tr, input logic [31:0] bad);
        vec_t v;
        v.stall = s; v.jb = j; v.rdy = r; v.tgt = t;
        v.e_pc = pc; v.e_fv = fv; v.e_fl = fl; v.e_pd = pd;
        v.e_trap = tr; v.e_bad = bad;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Drive one vector, push its expectation, sample after the edge and compare.
    task automatic apply(input vec_t v, input int idx);
        vec_t e;
        @(negedge clk);
        stall      = v.stall;
        jb_valid   = v.jb;
        jb_target  = v.tgt;
        imem_ready = v.rdy;
        exp_q.push_back(v);
        @(posedge clk);
        #1;
        e = exp_q.pop_front();
        check($sformatf("v%0d pc_out", idx), pc_out, e.e_pc);
        check($sformatf("v%0d fetch_valid", idx), 32'(fetch_valid), 32'(e.e_fv));
        check($sformatf("v%0d flush", idx), 32'(flush), 32'(e.e_fl));
        check($sformatf("v%0d redirect_pending", idx), 32'(redirect_pending), 32'(e.e_pd));
`ifdef PC_MISALIGN_TRAP_EN
        check($sformatf("v%0d misalign_trap", idx), 32'(misalign_trap), 32'(e.e_trap));
        check($sformatf("v%0d bad_addr", idx), bad_addr, e.e_bad);
`endif
    endtask

    task automatic check_reset(input string tag);
        check({tag, " pc_out"}, pc_out, 32'h0);
        check({tag, " fetch_valid"}, 32'(fetch_valid), 32'h0);
        check({tag, " flush"}, 32'(flush), 32'h0);
        check({tag, " redirect_pending"}, 32'(redirect_pending), 32'h0);
`ifdef PC_MISALIGN_TRAP_EN
        check({tag, " misalign_trap"}, 32'(misalign_trap), 32'h0);
        check({tag, " bad_addr"}, bad_addr, 32'h0);
`endif
    endtask

    logic [31:0] pc_v31;

    initial begin
`ifdef PC_MISALIGN_TRAP_EN
        pc_v31 = 32'h0000_0100;
`else
        pc_v31 = 32'h0000_0200;
`endif
        //            stall jb rdy target        pc            fv fl pd tr bad
        // Boot and sequential fetch
        vecs.push_back(mk(0, 0, 1, 32'h0,         32'h0,         1, 0, 0, 0, 32'h0));   // 0 BOOT->RUN
        vecs.push_back(mk(0, 0, 1, 32'h0,         32'h4,         1, 0, 0, 0, 32'h0));   // 1
        vecs.push_back(mk(0, 0, 1, 32'h0,         32'h8,         1, 0, 0, 0, 32'h0));   // 2
        // Stall holds the PC
        vecs.push_back(mk(1, 0, 1, 32'h0,         32'h8,         1, 0, 0, 0, 32'h0));   // 3
        vecs.push_back(mk(1, 0, 1, 32'h0,         32'h8,         1, 0, 0, 0, 32'h0));   // 4
        vecs.push_back(mk(1, 0, 1, 32'h0,         32'h8,         1, 0, 0, 0, 32'h0));   // 5
        vecs.push_back(mk(0, 0, 1, 32'h0,         32'hC,         1, 0, 0, 0, 32'h0));   // 6
        vecs.push_back(mk(0, 0, 1, 32'h0,         32'h10,        1, 0, 0, 0, 32'h0));   // 7
        // Immediate redirect, flush for two cycles
        vecs.push_back(mk(0, 1, 1, 32'h200,       32'h200,       1, 1, 0, 0, 32'h0));   // 8
        vecs.push_back(mk(0, 0, 0, 32'h0,         32'h200,       1, 1, 0, 0, 32'h0));   // 9
        vecs.push_back(mk(0, 0, 1, 32'h0,         32'h204,       1, 0, 0, 0, 32'h0));   // 10
        // Deferred redirect
        vecs.push_back(mk(0, 1, 0, 32'h80,        32'h204,       1, 0, 1, 0, 32'h0));   // 11
        vecs.push_back(mk(0, 0, 0, 32'h0,         32'h204,       1, 0, 1, 0, 32'h0));   // 12
        vecs.push_back(mk(0, 0, 0, 32'h0,         32'h204,       1, 0, 1, 0, 32'h0));   // 13
        vecs.push_back(mk(0, 0, 1, 32'h0,         32'h80,        1, 1, 0, 0, 32'h0));   // 14
        // Redirect beats stall, and reloads the flush counter
        vecs.push_back(mk(1, 0, 1, 32'h0,         32'h80,        1, 1, 0, 0, 32'h0));   // 15
        vecs.push_back(mk(1, 1, 1, 32'h40,        32'h40,        1, 1, 0, 0, 32'h0));   // 16
        vecs.push_back(mk(0, 0, 0, 32'h0,         32'h40,        1, 1, 0, 0, 32'h0));   // 17
        vecs.push_back(mk(0, 0, 0, 32'h0,         32'h40,        1, 0, 0, 0, 32'h0));   // 18
        // Latched target overwritten while waiting
        vecs.push_back(mk(0, 1, 0, 32'h300,       32'h40,        1, 0, 1, 0, 32'h0));   // 19
        vecs.push_back(mk(0, 1, 0, 32'h340,       32'h40,        1, 0, 1, 0, 32'h0));   // 20
        vecs.push_back(mk(0, 0, 1, 32'h0,         32'h340,       1, 1, 0, 0, 32'h0));   // 21
        // New target in the completing cycle is used directly
        vecs.push_back(mk(0, 1, 0, 32'h500,       32'h340,       1, 1, 1, 0, 32'h0));   // 22
        vecs.push_back(mk(0, 1, 1, 32'h600,       32'h600,       1, 1, 0, 0, 32'h0));   // 23
        // Stall ignored while waiting
        vecs.push_back(mk(0, 1, 0, 32'h700,       32'h600,       1, 1, 1, 0, 32'h0));   // 24
        vecs.push_back(mk(1, 0, 1, 32'h0,         32'h700,       1, 1, 0, 0, 32'h0));   // 25
        // Misaligned immediate target (0x100 either as trap vector or masked)
        vecs.push_back(mk(0, 1, 1, 32'h102,       32'h100,       1, 1, 0, 1, 32'h102)); // 26
        // Wrap-around of the sequential increment
        vecs.push_back(mk(0, 1, 1, 32'hFFFF_FFFC, 32'hFFFF_FFFC, 1, 1, 0, 0, 32'h102)); // 27
        vecs.push_back(mk(0, 0, 1, 32'h0,         32'h0,         1, 1, 0, 0, 32'h102)); // 28
        vecs.push_back(mk(0, 0, 1, 32'h0,         32'h4,         1, 0, 0, 0, 32'h102)); // 29
        // Misaligned latched target, checked at acceptance
        vecs.push_back(mk(0, 1, 0, 32'h203,       32'h4,         1, 0, 1, 0, 32'h102)); // 30
        vecs.push_back(mk(0, 0, 1, 32'h0,         pc_v31,        1, 1, 0, 1, 32'h203)); // 31
        // Enter wait, then reset mid-wait
        vecs.push_back(mk(0, 1, 0, 32'h900,       pc_v31,        1, 1, 1, 0, 32'h203)); // 32

        rst_n      = 1'b0;
        stall      = 1'b0;
        jb_valid   = 1'b0;
        jb_target  = 32'h0;
        imem_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check_reset("reset");
        #1 rst_n = 1'b1;

        for (int i = 0; i < vecs.size(); i++) apply(vecs[i], i);

        // Asynchronous reset while a redirect is latched.
        #1 rst_n = 1'b0;
        #1;
        check_reset("midwait_reset");
        @(posedge clk);
        #2 rst_n = 1'b1;
        apply(mk(0, 0, 1, 32'h0, 32'h0, 1, 0, 0, 0, 32'h0), 33);
        apply(mk(0, 0, 1, 32'h0, 32'h4, 1, 0, 0, 0, 32'h0), 34);

        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard: %0d entries left, expected 0", exp_q.size());
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
